layer2_pool_writer: RTL and testbench
=====================================

// Module: layer2_pool_writer
// PURPOSE
// - Stage directly upstream of the layer-2 result memory: takes the layer-2 conv output stream
//   (one packed multi-channel pixel per handshake, raster order), applies 2x2/stride-2 max-pool
//   and ReLU per channel, and emits save_enable/save_row_addr/save_col_addr/store data.
// - The pooled OUT_W x OUT_W map is the layer-3 input. A one-cycle done pulse marks the last write.
// PARAMETERS
// - CH     8   channels per packed pixel.
// - DW     16  bits per channel, signed two's complement. CH*DW == `LAYER2_OUTPUT_LENGTH.
// - IN_W   16  conv output width = height. Even, >=2.
// - OUT_W  8   pooled width = IN_W/2 == `LAYER3_WIDTH.
// PORTS
// - clk                           in   1      clock, rising edge
// - rst                           in   1      asynchronous, active-low reset
// - clear                         in   1      sync abort: counters/regs to reset state, drop in-flight write
// - in_valid                      in   1      conv pixel valid
// - in_ready                      out  1      stage accepts pixel; transfer = in_valid & in_ready
// - in_data                       in   CH*DW  packed pixel, channel k at [k*DW +: DW]
// - save_enable                   out  1      write strobe to result memory
// - save_row_addr                 out  16     pooled row, 0..OUT_W-1
// - save_col_addr                 out  16     pooled col, 0..OUT_W-1
// - layer2_result_store_data_in   out  CH*DW  pooled+ReLU pixel
// - layer2_done                   out  1      1-cycle pulse with the final write (row=col=OUT_W-1)
// BEHAVIOUR
// - Reset (rst=0): all outputs 0; row/col counters 0; h_reg and line buffer 0; in_ready 0
//   until the first clk edge after reset release, then 1.
// - in_ready = 1 whenever out of reset and not in clear; no back-pressure from memory
//   (the memory accepts one write per cycle).
// - Counters icol, irow (0..IN_W-1) advance only on transfer; icol wraps to 0 -> irow++;
//   at irow=IN_W-1, icol=IN_W-1 both wrap to 0 (next frame starts with no gap).
// - Per-channel signed max; ReLU: negative -> 0. Compare at full DW, no width growth.
// - Transfer actions (pos = icol>>1):
//     even row, even col: h_reg <= in_data
//     even row, odd  col: linebuf[pos] <= max(h_reg, in_data)
//     odd  row, even col: h_reg <= max(linebuf[pos], in_data)
//     odd  row, odd  col: write pooled = relu(max(h_reg, in_data))
// - Write latency: save_enable, addresses and data are registered and valid the cycle after the
//   odd/odd transfer. save_row_addr = irow>>1, save_col_addr = icol>>1, zero-extended to 16 bits.
// - save_enable is high exactly one cycle per pooled pixel; back-to-back writes are legal.
//   Address/data hold their last value when save_enable=0.
// - in_valid gaps (stalls): no state change, no write.
// - layer2_done is asserted in the same cycle as the save_enable of pooled (OUT_W-1, OUT_W-1).
// - clear: takes priority over a same-cycle transfer; that pixel is dropped. A write registered
//   in the previous cycle still appears, so clear blocks only a write not yet registered.
//   Counters -> 0, h_reg and linebuf -> 0, in_ready 0 for that cycle.
// - Async reset mid-frame: immediate return to reset state; partial frame discarded.
// STRUCTURE
// - Shared package (cnn_pkg): CH, DW, IN_W, OUT_W constants; typedef pixel_t = logic [CH*DW-1:0];
//   function relu_max(a,b) (per-channel signed max + clamp). `LAYER2_OUTPUT_LENGTH/`LAYER3_WIDTH
//   come from def.svh and must match.
// - One sub-module: pool_max_ch (per-channel signed max with optional ReLU), instantiated CH times
//   via generate. linebuf: OUT_W x CH*DW flops with an async-reset array.
// TESTING
// - Reset: hold rst=0 for 3 cycles -> all outputs 0, in_ready 0; release -> in_ready 1 next cycle.
// - Ramp frame: pixel(r,c) all channels = r*16+c, continuous valid -> 64 writes, (i,j) data =
//   (2i+1)*16+2j+1 per channel, addrs (i,j), done with (7,7) only.
// - ReLU/sign: a 2x2 block {-5,-3,-7,-1} -> 0; block {-5,3,-7,-1} -> 3; ch0 = 0x8000, ch1 = 0x7FFF
//   -> 0 and 0x7FFF.
// - Stalls: random in_valid (~40% duty) on the ramp frame -> identical write sequence; each write
//   is exactly 1 cycle after its odd/odd transfer.
// - Clear mid-frame at irow=5 (pooled row 2 odd row), then a full new frame -> no write from the old
//   frame after the cycle following clear; new frame addresses start at (0,0); 64 correct writes.
// - Async reset mid-frame and two frames back-to-back -> immediate zeroed outputs; second frame
//   writes start at (0,0) and layer2_done pulses once per frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants, pixel type and pooling helper for the layer-2 pool/write stage.
// Layer sizes come from def.svh when it is included ahead of this file. Otherwise the
// defaults below apply. CH and OUT_W are derived from those macros so they always agree.
`ifndef LAYER2_OUTPUT_LENGTH
`define LAYER2_OUTPUT_LENGTH 128
`endif
`ifndef LAYER3_WIDTH
`define LAYER3_WIDTH 8
`endif

package cnn_pkg;

    localparam int DW    = 16;                          // bits per channel, signed
    localparam int CH    = `LAYER2_OUTPUT_LENGTH / DW;  // channels per packed pixel
    localparam int OUT_W = `LAYER3_WIDTH;               // pooled map width/height
    localparam int IN_W  = 2 * OUT_W;                   // conv map width/height
    localparam int PW    = CH * DW;                     // packed pixel width
    localparam int CW    = $clog2(IN_W);                // conv row/col counter width
    localparam int AW    = 16;                          // result memory address width

    typedef logic [PW-1:0] pixel_t;

    // Per-channel signed max of two packed pixels, with negative results clamped to 0
    function automatic pixel_t relu_max(input pixel_t a, input pixel_t b);
        pixel_t           r;
        logic [DW-1:0]    ca;
        logic [DW-1:0]    cb;
        logic [DW-1:0]    m;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            ca = a[k*DW +: DW];
            cb = b[k*DW +: DW];
            m  = ($signed(ca) >= $signed(cb)) ? ca : cb;
            r[k*DW +: DW] = m[DW-1] ? '0 : m;
        end
        return r;
    endfunction

endpackage

// File: rtl/pool_max_ch.sv
// One channel of the pooling datapath: signed max of two values, plus the ReLU-clamped max.
module pool_max_ch #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] max_out,
    output logic [DW-1:0] relu_out
);

    // Full-width signed compare; the clamp only looks at the sign bit of the winner
    always_comb begin
        max_out  = ($signed(a) >= $signed(b)) ? a : b;
        relu_out = max_out[DW-1] ? '0 : max_out;
    end

endmodule

// File: rtl/layer2_pool_writer.sv
// Layer-2 conv stream -> 2x2/stride-2 max-pool + ReLU -> layer-2 result memory writes.
// Handshake: a pixel transfers on any rising edge where in_valid and in_ready are both 1;
// in_ready depends only on reset/clear, never on in_valid, and the memory side never stalls.
// Even rows build horizontal pair maxima in h_reg and park them in linebuf; odd rows fold
// the parked value back in so that the odd/odd pixel completes a 2x2 window and emits a write.
module layer2_pool_writer
    import cnn_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  pixel_t        in_data,
    output logic          save_enable,
    output logic [AW-1:0] save_row_addr,
    output logic [AW-1:0] save_col_addr,
    output pixel_t        layer2_result_store_data_in,
    output logic          layer2_done
);

    localparam logic [CW-1:0] LAST_IDX = CW'(IN_W - 1);

    logic [CW-1:0]   icol;
    logic [CW-1:0]   irow;
    logic            ready_q;
    logic            xfer;
    logic            row_odd;
    logic            col_odd;
    logic [CW-2:0]   pos;
    pixel_t          h_reg;
    pixel_t          linebuf [OUT_W];
    pixel_t          cmp_a;
    pixel_t          max_px;
    pixel_t          relu_px;

    assign in_ready = ready_q & ~clear;
    assign xfer     = in_valid & in_ready;
    assign row_odd  = irow[0];
    assign col_odd  = icol[0];
    assign pos      = icol[CW-1:1];

    // Odd-row even-col pixels fold in the parked even-row pair; every other case uses h_reg
    always_comb begin
        cmp_a = h_reg;
        if (row_odd && !col_odd) begin
            cmp_a = linebuf[pos];
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        pool_max_ch #(.DW(DW)) u_max (
            .a        (cmp_a[k*DW +: DW]),
            .b        (in_data[k*DW +: DW]),
            .max_out  (max_px[k*DW +: DW]),
            .relu_out (relu_px[k*DW +: DW])
        );
    end

    // in_ready comes up on the first clock edge after reset is released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Raster position of the next pixel; wraps into the next frame without a gap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            icol <= '0;
            irow <= '0;
        end else if (clear) begin
            icol <= '0;
            irow <= '0;
        end else if (xfer) begin
            if (icol == LAST_IDX) begin
                icol <= '0;
                irow <= (irow == LAST_IDX) ? '0 : irow + CW'(1);
            end else begin
                icol <= icol + CW'(1);
            end
        end
    end

    // Horizontal partial: raw pixel on even/even, vertical fold on odd/even
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_reg <= '0;
        end else if (clear) begin
            h_reg <= '0;
        end else if (xfer && !col_odd) begin
            h_reg <= row_odd ? max_px : in_data;
        end
    end

    // Line buffer holds one pair maximum per pooled column between the two rows of a window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OUT_W; i++) begin
                linebuf[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < OUT_W; i++) begin
                linebuf[i] <= '0;
            end
        end else if (xfer && !row_odd && col_odd) begin
            linebuf[pos] <= max_px;
        end
    end

    // Registered write port: strobe for one cycle per window, address/data hold otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            save_enable                 <= 1'b0;
            save_row_addr               <= '0;
            save_col_addr               <= '0;
            layer2_result_store_data_in <= '0;
            layer2_done                 <= 1'b0;
        end else if (clear) begin
            save_enable                 <= 1'b0;
            save_row_addr               <= '0;
            save_col_addr               <= '0;
            layer2_result_store_data_in <= '0;
            layer2_done                 <= 1'b0;
        end else begin
            save_enable <= 1'b0;
            layer2_done <= 1'b0;
            if (xfer && row_odd && col_odd) begin
                save_enable                 <= 1'b1;
                save_row_addr               <= AW'(irow[CW-1:1]);
                save_col_addr               <= AW'(icol[CW-1:1]);
                layer2_result_store_data_in <= relu_px;
                layer2_done                 <= (irow == LAST_IDX) && (icol == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_layer2_pool_writer.sv
// Bench for layer2_pool_writer: randomized streams against a frame-level pooling model.
module tb_layer2_pool_writer;
    import cnn_pkg::*;

    localparam int NPIX = IN_W * IN_W;
    localparam int EW   = 1 + 2 * AW + PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    pixel_t        in_data = '0;
    logic          save_enable;
    logic [AW-1:0] save_row_addr;
    logic [AW-1:0] save_col_addr;
    pixel_t        store_data;
    logic          layer2_done;

    layer2_pool_writer dut (
        .clk                         (clk),
        .rst                         (rst),
        .clear                       (clear),
        .in_valid                    (in_valid),
        .in_ready                    (in_ready),
        .in_data                     (in_data),
        .save_enable                 (save_enable),
        .save_row_addr               (save_row_addr),
        .save_col_addr               (save_col_addr),
        .layer2_result_store_data_in (store_data),
        .layer2_done                 (layer2_done)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model state ----------------
    int             n_cmp = 0;
    int             n_bad = 0;
    int             done_cnt = 0;
    int             wr_cnt = 0;
    int             pos_m = 0;
    logic           ready_m;
    pixel_t         frame_mem [NPIX];
    pixel_t         img [IN_W][IN_W];
    pixel_t         got [OUT_W][OUT_W];
    logic [EW-1:0]  exp_q [$];
    logic [EW-1:0]  e;
    int             mr;
    int             mc;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic pixel_t rand_px();
        pixel_t p;
        for (int k = 0; k < CH; k++) p[k*DW +: DW] = DW'($urandom);
        return p;
    endfunction

    function automatic pixel_t all_ch(input logic [DW-1:0] v);
        pixel_t p;
        for (int k = 0; k < CH; k++) p[k*DW +: DW] = v;
        return p;
    endfunction

    // Reference window result: signed max over the four pixels of the window, floor at 0
    function automatic pixel_t pool_ref(input int pr, input int pc);
        pixel_t        o;
        logic [DW-1:0] t;
        int            m;
        int            v;
        pixel_t        px;
        for (int k = 0; k < CH; k++) begin
            m = -(1 << 30);
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    px = img[2*pr+dr][2*pc+dc];
                    t  = px[k*DW +: DW];
                    v  = int'($signed(t));
                    if (v > m) m = v;
                end
            end
            if (m < 0) m = 0;
            o[k*DW +: DW] = DW'(m);
        end
        return o;
    endfunction

    // Ramp frame window (i,j): bottom-right pixel wins, value (2i+1)*16 + 2j+1 on every channel
    function automatic pixel_t ramp_pool(input int i, input int j);
        return all_ch(DW'((2*i+1)*16 + 2*j + 1));
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) ready_m <= 1'b0;
        else      ready_m <= 1'b1;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_save_enable", PW'(save_enable), '0);
            chk("rst_done", PW'(layer2_done), '0);
            chk("rst_row", PW'(save_row_addr), '0);
            chk("rst_col", PW'(save_col_addr), '0);
            chk("rst_data", store_data, '0);
            chk("rst_in_ready", PW'(in_ready), '0);
            exp_q.delete();
            pos_m = 0;
        end else begin
            chk("in_ready", PW'(in_ready), PW'(ready_m & ~clear));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("save_enable", PW'(save_enable), PW'(1));
                chk("layer2_done", PW'(layer2_done), PW'(e[EW-1]));
                chk("save_row_addr", PW'(save_row_addr), PW'(e[EW-2 -: AW]));
                chk("save_col_addr", PW'(save_col_addr), PW'(e[PW+AW-1 -: AW]));
                chk("store_data", store_data, e[PW-1:0]);
                if (save_row_addr < AW'(OUT_W) && save_col_addr < AW'(OUT_W))
                    got[save_row_addr][save_col_addr] = store_data;
            end else begin
                chk("idle_save_enable", PW'(save_enable), '0);
                chk("idle_done", PW'(layer2_done), '0);
            end
            if (save_enable) wr_cnt++;
            if (layer2_done) done_cnt++;
            // Predict what the coming edge does
            if (clear) begin
                pos_m = 0;
            end else if (in_valid && in_ready) begin
                mr = pos_m / IN_W;
                mc = pos_m % IN_W;
                img[mr][mc] = in_data;
                if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                    exp_q.push_back({(mr == IN_W-1) && (mc == IN_W-1),
                                     AW'(mr / 2), AW'(mc / 2), pool_ref(mr / 2, mc / 2)});
                end
                pos_m = (pos_m + 1) % NPIX;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pixels(input int first, input int count, input int duty);
        int   idx = 0;
        int   cycles = 0;
        logic acc;
        while (idx < count) begin
            in_valid = ($urandom_range(0, 99) < duty);
            in_data  = in_valid ? frame_mem[(first + idx) % NPIX] : rand_px();
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cycles++;
            if (cycles > count * 20 + 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: sent %0d of %0d pixels", idx, count);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", PW'(exp_q.size()), '0);
    endtask

    task automatic start_phase();
        done_cnt = 0;
        wr_cnt   = 0;
        for (int i = 0; i < OUT_W; i++)
            for (int j = 0; j < OUT_W; j++) got[i][j] = '0;
    endtask

    task automatic load_ramp();
        for (int r = 0; r < IN_W; r++)
            for (int c = 0; c < IN_W; c++) frame_mem[r*IN_W + c] = all_ch(DW'(r*16 + c));
    endtask

    task automatic load_random();
        for (int i = 0; i < NPIX; i++) frame_mem[i] = rand_px();
    endtask

    task automatic check_ramp(input string nm);
        for (int i = 0; i < OUT_W; i++)
            for (int j = 0; j < OUT_W; j++) chk(nm, got[i][j], ramp_pool(i, j));
        chk({nm, "_writes"}, PW'(wr_cnt), PW'(OUT_W * OUT_W));
        chk({nm, "_done"}, PW'(done_cnt), PW'(1));
    endtask

    // ---------------- main sequence ----------------
    pixel_t p;
    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("ready_before_edge", PW'(in_ready), '0);
        @(posedge clk);
        #1;
        chk("ready_after_release", PW'(in_ready), PW'(1));

        // Ramp frame, continuous valid
        load_ramp();
        start_phase();
        send_pixels(0, NPIX, 100);
        drain();
        check_ramp("ramp");

        // Sign and ReLU corner cases in the first pooled row
        load_random();
        frame_mem[0]          = all_ch(-16'sd5);
        frame_mem[1]          = all_ch(-16'sd3);
        frame_mem[IN_W]       = all_ch(-16'sd7);
        frame_mem[IN_W + 1]   = all_ch(-16'sd1);
        frame_mem[2]          = all_ch(-16'sd5);
        frame_mem[3]          = all_ch(16'sd3);
        frame_mem[IN_W + 2]   = all_ch(-16'sd7);
        frame_mem[IN_W + 3]   = all_ch(-16'sd1);
        for (int c = 4; c < 6; c++) begin
            for (int r = 0; r < 2; r++) begin
                p = frame_mem[r*IN_W + c];
                p[0 +: DW]  = 16'h8000;
                p[DW +: DW] = 16'h7FFF;
                frame_mem[r*IN_W + c] = p;
            end
        end
        start_phase();
        send_pixels(0, NPIX, 70);
        drain();
        chk("relu_all_neg", got[0][0], '0);
        chk("relu_one_pos", got[0][1], all_ch(16'd3));
        p = got[0][2];
        chk("relu_min_ch0", PW'(p[0 +: DW]), '0);
        chk("relu_max_ch1", PW'(p[DW +: DW]), PW'(16'h7FFF));
        chk("sign_writes", PW'(wr_cnt), PW'(OUT_W * OUT_W));

        // Ramp frame with ~40% valid duty
        load_ramp();
        start_phase();
        send_pixels(0, NPIX, 40);
        drain();
        check_ramp("stall_ramp");

        // Random data frame, random duty
        load_random();
        start_phase();
        send_pixels(0, NPIX, $urandom_range(30, 100));
        drain();
        chk("rand_writes", PW'(wr_cnt), PW'(OUT_W * OUT_W));
        chk("rand_done", PW'(done_cnt), PW'(1));

        // Clear at input row 5, just after an odd/odd transfer, with a pixel offered
        load_ramp();
        send_pixels(0, 5 * IN_W + 4, 100);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_px();
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        start_phase();
        send_pixels(0, NPIX, 100);
        drain();
        check_ramp("after_clear");

        // Async reset mid-frame, then two frames back to back
        load_random();
        send_pixels(0, 100, 100);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("async_save_enable", PW'(save_enable), '0);
        chk("async_data", store_data, '0);
        chk("async_in_ready", PW'(in_ready), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        start_phase();
        send_pixels(0, 2 * NPIX, 85);
        drain();
        chk("b2b_writes", PW'(wr_cnt), PW'(2 * OUT_W * OUT_W));
        chk("b2b_done", PW'(done_cnt), PW'(2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
